// File: rtl/adder_rate_pkg.sv
// adder_rate_pkg: shared types and helpers for the adder rate meter.
//   state_t    : measurement FSM states (IDLE, PRIME, RUN).
//   rate_delta : modulo difference between two counter samples.
package adder_rate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Difference between the current and the previous counter sample. The
    // result is 32 bits wide; the caller truncates it to the counter width,
    // which turns the plain subtraction into arithmetic modulo 2^WIDTH.
    // Because of that truncation, a counter that wrapped inside the window
    // still yields the right increment count.
    function automatic logic [31:0] rate_delta(input logic [31:0] cur,
                                               input logic [31:0] prev);
        return cur - prev;
    endfunction

endpackage

// File: rtl/adder_rate_meter_if.sv
// adder_rate_meter_if: output channel of the rate meter.
//   rate_valid : a delta is available (driven by master)
//   rate_ready : consumer accepts the delta (driven by slave)
//   rate_data  : increments counted in the last window (driven by master)
//
// Handshake: a transfer happens on every rising edge where rate_valid and
// rate_ready are both high. Once rate_valid is raised, rate_valid and
// rate_data hold steady until that transfer takes place; rate_ready may
// change freely and never depends on rate_valid combinationally.
interface adder_rate_meter_if #(
    parameter int WIDTH = 8
);
    logic             rate_valid;
    logic             rate_ready;
    logic [WIDTH-1:0] rate_data;

    modport master (output rate_valid, output rate_data, input rate_ready);
    modport slave  (input rate_valid, input rate_data, output rate_ready);
endinterface

// File: rtl/adder_rate_meter_window_timer.sv
// window_timer: free-running window counter for the rate meter.
//   aclk  : clock, rising edge
//   arstn : asynchronous active-low reset
//   en    : count enable; when low the timer is forced back to 0
//   tick  : high while the timer sits at WINDOW-1 (last cycle of a window)
module window_timer #(
    parameter int WINDOW = 16
) (
    input  logic aclk,
    input  logic arstn,
    input  logic en,
    output logic tick
);
    localparam int TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);

    logic [TW-1:0] timer;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            timer <= '0;
        end else if (!en) begin
            timer <= '0;
        end else if (timer == LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign tick = (timer == LAST);

endmodule

// File: rtl/adder_rate_meter.sv
// adder_rate_meter: samples a free-running counter every WINDOW cycles and
// reports the number of increments seen in each window.
//   aclk      : clock, rising edge
//   arstn     : asynchronous active-low reset
//   en        : measurement enable
//   cnt_in    : counter value being measured
//   cnt_clr   : copy of the counter's clear (counter reads 0 next cycle)
//   rate      : valid/ready channel carrying each window's delta
//   rate_ovf  : sticky, a delta was dropped because the channel was busy
//   ovf_clr   : clears rate_ovf (a simultaneous drop wins)
//   state_dbg : current FSM state
module adder_rate_meter
    import adder_rate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic                       aclk,
    input  logic                       arstn,
    input  logic                       en,
    input  logic [WIDTH-1:0]           cnt_in,
    input  logic                       cnt_clr,
    adder_rate_meter_if.master         rate,
    output logic                       rate_ovf,
    input  logic                       ovf_clr,
    output state_t                     state_dbg
);
    state_t           state;
    state_t           state_nxt;
    logic             timer_en;
    logic             tick;
    logic             prime_edge;
    logic             sample_edge;
    logic             xfer;
    logic             drop;
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] delta;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // The timer only runs once the FSM has left IDLE, so the first window
    // after enabling starts counting on the cycle after en is seen.
    assign timer_en = en && (state != IDLE);

    window_timer #(
        .WINDOW (WINDOW)
    ) u_timer (
        .aclk  (aclk),
        .arstn (arstn),
        .en    (timer_en),
        .tick  (tick)
    );

    assign prime_edge  = en && tick && (state == PRIME);
    assign sample_edge = en && tick && (state == RUN);
    assign delta       = WIDTH'(rate_delta(32'(cnt_in), 32'(last)));
    assign xfer        = valid_q && rate.rate_ready;
    assign drop        = sample_edge && valid_q && !rate.rate_ready;

    // FSM state register
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = PRIME;
            PRIME: begin
                if (!en)             state_nxt = IDLE;
                else if (prime_edge) state_nxt = RUN;
            end
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Baseline sample. A counter clear always wins over the load because the
    // counter restarts from 0 on the following cycle. last survives en=0 so
    // a later re-prime simply overwrites it.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            last <= '0;
        end else if (cnt_clr) begin
            last <= '0;
        end else if (prime_edge || sample_edge) begin
            last <= cnt_in;
        end
    end

    // Output register. A new delta is accepted when the slot is empty or is
    // being emptied in this same cycle; otherwise it is dropped and flagged.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (sample_edge && (!valid_q || xfer)) begin
            valid_q <= 1'b1;
            data_q  <= delta;
        end else if (xfer) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rate_ovf <= 1'b0;
        end else if (drop) begin
            rate_ovf <= 1'b1;
        end else if (ovf_clr) begin
            rate_ovf <= 1'b0;
        end
    end

    assign rate.rate_valid = valid_q;
    assign rate.rate_data  = data_q;
    assign state_dbg       = state;

endmodule

// File: tb/tb_adder_rate_meter.sv
// tb_adder_rate_meter: directed test of adder_rate_meter (WIDTH=8, WINDOW=16).
// The initial block owns a small counter model driving cnt_in; expected
// deltas are worked out by hand from the sample-edge schedule.
module tb_adder_rate_meter;
    import adder_rate_pkg::*;

    logic       aclk = 1'b0;
    logic       arstn;
    logic       en;
    logic [7:0] cnt_in;
    logic       cnt_clr;
    logic       rate_ovf;
    logic       ovf_clr;
    state_t     state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int inc      = 0;

    adder_rate_meter_if #(.WIDTH(8)) rif ();

    adder_rate_meter #(
        .WIDTH  (8),
        .WINDOW (16)
    ) dut (
        .aclk      (aclk),
        .arstn     (arstn),
        .en        (en),
        .cnt_in    (cnt_in),
        .cnt_clr   (cnt_clr),
        .rate      (rif),
        .rate_ovf  (rate_ovf),
        .ovf_clr   (ovf_clr),
        .state_dbg (state_dbg)
    );

    // clock
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled 1 time unit after the
    // rising edge. The counter model clears or advances by inc.
    task automatic step();
        @(posedge aclk);
        #1;
        cyc++;
        if (cnt_clr) cnt_in = 8'h00;
        else         cnt_in = cnt_in + 8'(inc);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        arstn          = 1'b1;
        en             = 1'b0;
        cnt_in         = 8'h00;
        cnt_clr        = 1'b0;
        ovf_clr        = 1'b0;
        rif.rate_ready = 1'b0;
        #1 arstn = 1'b0;
        #1;
        chk("rst_valid", 32'(rif.rate_valid), 32'd0);
        chk("rst_data",  32'(rif.rate_data),  32'd0);
        chk("rst_ovf",   32'(rate_ovf),       32'd0);
        chk("rst_state", 32'(state_dbg),      32'(IDLE));
        repeat (2) @(posedge aclk);
        #1;
        arstn          = 1'b1;
        en             = 1'b1;
        rif.rate_ready = 1'b1;
        inc            = 1;
        cyc            = 0;

        // Steady counting: prime at edge 17, then a delta of 16 per window.
        run_to(1);  chk("t1_prime_state", 32'(state_dbg), 32'(PRIME));
        run_to(17); chk("t1_run_state",   32'(state_dbg), 32'(RUN));
        chk("t1_no_prime_out", 32'(rif.rate_valid), 32'd0);
        run_to(32); chk("t1_pre_valid", 32'(rif.rate_valid), 32'd0);
        run_to(33);
        chk("t1_valid1", 32'(rif.rate_valid), 32'd1);
        chk("t1_data1",  32'(rif.rate_data),  32'd16);
        chk("t1_ovf",    32'(rate_ovf),       32'd0);
        run_to(34); chk("t1_xfer_drop", 32'(rif.rate_valid), 32'd0);
        run_to(49);
        chk("t1_valid2", 32'(rif.rate_valid), 32'd1);
        chk("t1_data2",  32'(rif.rate_data),  32'd16);
        run_to(65); chk("t1_data3", 32'(rif.rate_data), 32'd16);

        // Wrap-around: last=250 at edge 81, cnt_in=16 at edge 97.
        run_to(80); cnt_in = 8'd250; inc = 0;
        run_to(81); chk("t2_jump", 32'(rif.rate_data), 32'd186);
        run_to(96); cnt_in = 8'd16; rif.rate_ready = 1'b0;
        run_to(97);
        chk("t2_wrap_valid", 32'(rif.rate_valid), 32'd1);
        chk("t2_wrap_data",  32'(rif.rate_data),  32'd22);

        // Backpressure: 22 held, the zero delta at edge 113 is dropped.
        run_to(105);
        chk("t3_hold_valid", 32'(rif.rate_valid), 32'd1);
        chk("t3_hold_data",  32'(rif.rate_data),  32'd22);
        run_to(113);
        chk("t3_drop_data", 32'(rif.rate_data), 32'd22);
        chk("t3_drop_ovf",  32'(rate_ovf),      32'd1);
        rif.rate_ready = 1'b1;
        run_to(114);
        chk("t3_drain_valid", 32'(rif.rate_valid), 32'd0);
        chk("t3_ovf_sticky",  32'(rate_ovf),       32'd1);
        run_to(129);
        chk("t3_zero_valid", 32'(rif.rate_valid), 32'd1);
        chk("t3_zero_data",  32'(rif.rate_data),  32'd0);

        // Overflow clear: same-cycle drop wins, then a lone clear works.
        rif.rate_ready = 1'b0;
        run_to(130); cnt_in = 8'd30;
        run_to(144); ovf_clr = 1'b1;
        run_to(145); ovf_clr = 1'b0;
        chk("t5_set_wins", 32'(rate_ovf),      32'd1);
        chk("t5_held",     32'(rif.rate_data), 32'd0);
        run_to(146); ovf_clr = 1'b1;
        run_to(147); ovf_clr = 1'b0; rif.rate_ready = 1'b1;
        chk("t5_cleared", 32'(rate_ovf), 32'd0);
        run_to(148); chk("t5_drain", 32'(rif.rate_valid), 32'd0);

        // Counter clear mid-window at 40, then 5 increments.
        run_to(150); cnt_in = 8'd40;
        run_to(152); cnt_clr = 1'b1;
        run_to(153); cnt_clr = 1'b0; inc = 1;
        run_to(158); inc = 0;
        run_to(161);
        chk("t4_mid_valid", 32'(rif.rate_valid), 32'd1);
        chk("t4_mid_data",  32'(rif.rate_data),  32'd5);
        // Counter clear on the sample edge: last=100, cnt_in=110.
        run_to(176); cnt_in = 8'd100;
        run_to(177); chk("t4_base", 32'(rif.rate_data), 32'd95);
        run_to(178); cnt_in = 8'd110;
        run_to(192); cnt_clr = 1'b1;
        run_to(193); cnt_clr = 1'b0; inc = 1;
        chk("t4_edge_data", 32'(rif.rate_data), 32'd10);
        run_to(209);
        chk("t4_from_zero", 32'(rif.rate_data), 32'd15);
        inc = 0; rif.rate_ready = 1'b0;

        // Asynchronous reset while a delta is pending and ovf is set.
        run_to(225);
        chk("t6_pre_valid", 32'(rif.rate_valid), 32'd1);
        chk("t6_pre_data",  32'(rif.rate_data),  32'd15);
        chk("t6_pre_ovf",   32'(rate_ovf),       32'd1);
        run_to(230);
        #2 arstn = 1'b0;
        #1;
        chk("t6_async_valid", 32'(rif.rate_valid), 32'd0);
        chk("t6_async_data",  32'(rif.rate_data),  32'd0);
        chk("t6_async_ovf",   32'(rate_ovf),       32'd0);
        chk("t6_async_state", 32'(state_dbg),      32'(IDLE));
        step();
        arstn          = 1'b1;
        rif.rate_ready = 1'b1;
        inc            = 1;
        cyc            = 0;
        run_to(1);  chk("t6_reprime", 32'(state_dbg), 32'(PRIME));
        run_to(17); chk("t6_no_prime_out", 32'(rif.rate_valid), 32'd0);
        run_to(32); chk("t6_pre_first", 32'(rif.rate_valid), 32'd0);
        run_to(33);
        chk("t6_first_valid", 32'(rif.rate_valid), 32'd1);
        chk("t6_first_data",  32'(rif.rate_data),  32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_rate_meter.md
Name: adder_rate_meter

Overview:
- Downstream consumer of the free-running `Adder` counter.
- Samples the counter value `out` once every WINDOW cycles and computes the increment count per window, modulo 2^WIDTH.
- Presents each delta on a valid/ready output channel to a monitoring or stats block.
- Flags any sample lost to backpressure with a sticky overflow bit.

Parameters:
- WIDTH, 8: width of the counter value and of the delta.
- WINDOW, 16: sample period in aclk cycles; legal values are 2 to 65535.
- TW, $clog2(WINDOW): window-timer width; localparam, not overridable.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- arstn  in  1  reset, asynchronous and active-low.
- en  in  1  measurement enable.
- cnt_in  in  WIDTH  counter value, driven by the Adder `out` port.
- cnt_clr  in  1  copy of the Adder `clr` input (the counter reads 0 on the next cycle).
- rate_valid  out  1  a delta is available.
- rate_ready  in  1  the consumer accepts the delta.
- rate_data  out  WIDTH  increments counted in the last window.
- rate_ovf  out  1  sticky: at least one sample was dropped.
- ovf_clr  in  1  clears rate_ovf.

Behaviour:
- Reset (arstn low, asynchronous):
  - Outputs: rate_valid=0, rate_data=0, rate_ovf=0.
  - Internals: timer=0, last=0, state=IDLE.
  - Reset asserted mid-window discards any partial window and any pending output.
- FSM states: IDLE, PRIME, RUN.
  - IDLE: timer held at 0. en=1 moves to PRIME.
  - PRIME: timer counts. When timer==WINDOW-1: last<=cnt_in, no output, go to RUN. This sample only establishes the baseline.
  - RUN: timer counts 0..WINDOW-1 and wraps. Every cycle with timer==WINDOW-1 is a sample edge:
    - delta = (cnt_in - last) mod 2^WIDTH; plain WIDTH-bit subtraction, so wrap-around is correct.
    - last <= cnt_in.
  - en=0 in any state: go to IDLE, timer<=0 on the next edge, last is kept. A pending rate_valid stays held until it is consumed.
- cnt_clr:
  - Asserted in a cycle that is not a sample edge: last<=0. The counter restarts from 0, so the next delta counts from 0.
  - Asserted on a sample edge: delta is computed with the current cnt_in and the old last, then last<=0 (clear overrides the cnt_in load).
- Output register, standard valid/ready:
  - Transfer occurs when rate_valid & rate_ready.
  - At a sample edge in RUN, if rate_valid==0 or a transfer occurs in the same cycle: rate_data<=delta and rate_valid<=1 on that edge.
    - Latency: 1 cycle from the sample-edge cycle to rate_valid high.
  - Otherwise the new delta is dropped, rate_data is unchanged, and rate_ovf<=1.
  - Transfer without a new sample: rate_valid<=0.
  - rate_data and rate_valid are stable while rate_valid=1 and rate_ready=0.
- rate_ovf:
  - Set on a drop; cleared by ovf_clr.
  - Set and clear in the same cycle: set wins, rate_ovf stays 1.
- A delta of 0 is a legitimate value and is emitted.

Decomposition:
- Package adder_rate_pkg holds:
  - the state enum typedef (IDLE, PRIME, RUN);
  - a function for the modulo delta.
- One natural sub-module, window_timer:
  - parameter WINDOW;
  - inputs aclk, arstn, en;
  - output tick, high when timer==WINDOW-1.
- Everything else is in the top module.

Test Plan:
1. Adder with inc held at 1, en=1, rate_ready=1, WINDOW=16 → first sample primes only; every later window gives rate_valid with rate_data=16; rate_ovf=0.
2. Wrap-around: last=250, counter advances 22 so cnt_in=16 at the sample edge → rate_data=22.
3. Backpressure: rate_ready=0 across two sample edges → first delta held unchanged, second dropped, rate_ovf=1. rate_ready=1 then transfers the held value once, and rate_valid drops.
4. cnt_clr asserted mid-window with counter at 40, followed by 5 increments → next rate_data=5. cnt_clr asserted on the sample edge (last=100, cnt_in=110) → rate_data=10, and the following window counts from 0.
5. ovf_clr asserted in the same cycle as a new drop → rate_ovf stays 1. ovf_clr alone → rate_ovf=0 on the next edge.
6. arstn pulsed low mid-window while rate_valid=1 → all outputs 0 immediately (asynchronous); after release with en=1 the FSM re-primes and the first output appears at the end of the second window.
